// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the CPU data-port responder: state encodings and parameter defaults.
// The optional one-entry write buffer is enabled by defining the macro DMEM_WBUF_EN.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_DONE  = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    localparam int unsigned DEF_TIMEOUT_CYC = 255;
    localparam logic [31:0] DEF_ERR_DATA    = 32'h0000_0000;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_responder.sv
// Bridges the CPU data port onto a valid/ready memory handshake, stalling the CPU through o_ce.
// Define DMEM_WBUF_EN to absorb plain writes into a one-entry buffer without stalling.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [31:0] ERR_DATA    = DEF_ERR_DATA
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clk_ce,
    input  logic        i_req_rd,
    input  logic [3:0]  i_req_wr,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data,
    output logic        o_ce,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;
    logic        rd_q, rd_d;
    logic        rderr_q, rderr_d;
    logic        req_s, wr_s, tmo_s, absorb_s, stall_s;

    assign req_s = i_req_rd | (|i_req_wr);
    assign wr_s  = |i_req_wr;
    assign tmo_s = (cnt_q == TMO_LAST);

`ifdef DMEM_WBUF_EN
    logic wbuf_vld_q, wbuf_vld_d;
    // Only pure writes are absorbed; a read-with-write still needs a result from DONE.
    assign absorb_s = (state_q == ST_IDLE) & i_clk_ce & wr_s & ~i_req_rd & ~wbuf_vld_q;
`else
    assign absorb_s = 1'b0;
`endif

    // Reset holds the stall low so the CPU enable passes straight through.
    assign o_ce = i_clk_ce & ~(stall_s & i_rst_n);

    // Next-state, request capture and stall generation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        err_d       = err_q;
        rd_d        = rd_q;
        rderr_d     = rderr_q;
        stall_s     = 1'b0;
`ifdef DMEM_WBUF_EN
        wbuf_vld_d  = wbuf_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    stall_s = ~absorb_s;
                    if (i_clk_ce) begin
                        mem_addr_d  = word_addr(i_addr);
                        mem_wdata_d = i_wr_data;
                        mem_we_d    = wr_s;
                        mem_be_d    = wr_s ? i_req_wr : 4'b1111;
                        rd_d        = i_req_rd & ~wr_s;
                        rderr_d     = i_req_rd & wr_s;
                        mem_valid_d = 1'b1;
                        cnt_d       = 8'd0;
                        state_d     = absorb_s ? ST_DRAIN : ST_WAIT;
`ifdef DMEM_WBUF_EN
                        wbuf_vld_d  = absorb_s;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (mem_valid_q && i_mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_DONE;
                    if (rderr_q) begin
                        rd_data_d = ERR_DATA;
                    end else if (rd_q) begin
                        rd_data_d = i_mem_rdata;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                end else if (tmo_s) begin
                    mem_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ST_DONE;
                    if (rd_q || rderr_q) begin
                        rd_data_d = ERR_DATA;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (i_clk_ce) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
`ifdef DMEM_WBUF_EN
            ST_DRAIN: begin
                // New requests wait here and are taken from IDLE once the buffer empties.
                stall_s = req_s;
                if (mem_valid_q && i_mem_ready) begin
                    mem_valid_d = 1'b0;
                    wbuf_vld_d  = 1'b0;
                    state_d     = ST_IDLE;
                end else if (tmo_s) begin
                    mem_valid_d = 1'b0;
                    wbuf_vld_d  = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            rd_data_q   <= 32'h0000_0000;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            rderr_q     <= 1'b0;
`ifdef DMEM_WBUF_EN
            wbuf_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            rderr_q     <= rderr_d;
`ifdef DMEM_WBUF_EN
            wbuf_vld_q  <= wbuf_vld_d;
`endif
        end
    end

    assign o_rd_data   = rd_data_q;
    assign o_mem_valid = mem_valid_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_be    = mem_be_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stimulus pushes expected memory requests and completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_dmem_responder;

    localparam logic [31:0] ERR_W = 32'hDEAD_BEEF;
    localparam int          TMO   = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_clk_ce, i_req_rd, i_mem_ready;
    logic [3:0]  i_req_wr;
    logic [31:0] i_addr, i_wr_data, i_mem_rdata;
    logic [31:0] o_rd_data, o_mem_addr, o_mem_wdata;
    logic        o_ce, o_mem_valid, o_mem_we, o_err;
    logic [3:0]  o_mem_be;

    dmem_responder #(.TIMEOUT_CYC(TMO), .ERR_DATA(ERR_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clk_ce(i_clk_ce),
        .i_req_rd(i_req_rd), .i_req_wr(i_req_wr), .i_addr(i_addr), .i_wr_data(i_wr_data),
        .o_rd_data(o_rd_data), .o_ce(o_ce),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } cexp_t;

    mexp_t mq[$];
    cexp_t cq[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd  = 32'h0000_0000;
    logic        exp_err = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic void push_mem(input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        mexp_t m;
        m.addr  = {addr[31:2], 2'b00};
        m.we    = |be;
        m.be    = (|be) ? be : 4'b1111;
        m.wdata = wdata;
        mq.push_back(m);
    endfunction

    // Expected outcome: ready within TMO wait cycles wins, otherwise the error path.
    function automatic void push_txn(input logic rd, input logic [3:0] be, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [31:0] rdata, input int ready_at);
        cexp_t c;
        logic  timed_out;
        push_mem(be, addr, wdata);
        timed_out = (ready_at < 1) || (ready_at > TMO);
        if (rd && (|be))   exp_rd = ERR_W;
        else if (rd)       exp_rd = timed_out ? ERR_W : rdata;
        if (timed_out)     exp_err = 1'b1;
        c.rd  = exp_rd;
        c.err = exp_err;
        cq.push_back(c);
    endfunction

    task automatic run_txn(input logic rd, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ready_at, input logic [31:0] rdata,
                           input int exp_stall);
        int low = 0;
        int widx = 0;
        int guard = 0;
        @(posedge i_clk); #1;
        i_req_rd = rd; i_req_wr = be; i_addr = addr; i_wr_data = wdata; i_mem_rdata = rdata;
        push_txn(rd, be, addr, wdata, rdata, ready_at);
        @(negedge i_clk);
        while (o_ce == 1'b0 && guard < 300) begin
            low++;
            if (o_mem_valid) widx++;
            i_mem_ready = (o_mem_valid && widx == ready_at) ? 1'b1 : 1'b0;
            @(negedge i_clk);
            guard++;
        end
        i_mem_ready = 1'b0;
        chk("stall_cycles", 64'(low), 64'(exp_stall));
        @(posedge i_clk); #1;
        i_req_rd = 1'b0; i_req_wr = 4'b0000;
    endtask

    // Monitor: request fields on o_mem_valid rise and while held; completion on its fall.
    initial begin
        mexp_t cur;
        cexp_t c;
        bit    prev_v = 1'b0;
        cur = '{addr: 32'h0, we: 1'b0, be: 4'h0, wdata: 32'h0};
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (o_mem_valid && !prev_v) begin
                    if (mq.size() == 0) begin
                        chk("mem_unexpected", 64'(o_mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        cur = mq.pop_front();
                        chk("mem_addr", 64'(o_mem_addr), 64'(cur.addr));
                        chk("mem_we_be", 64'({o_mem_we, o_mem_be}), 64'({cur.we, cur.be}));
                        chk("mem_wdata", 64'(o_mem_wdata), 64'(cur.wdata));
                    end
                end else if (o_mem_valid && prev_v) begin
                    chk("mem_hold", {o_mem_addr, o_mem_wdata}, {cur.addr, cur.wdata});
                    chk("mem_hold_we_be", 64'({o_mem_we, o_mem_be}), 64'({cur.we, cur.be}));
                end
                if (!o_mem_valid && prev_v) begin
                    if (cq.size() == 0) begin
                        chk("done_unexpected", 64'(o_rd_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        c = cq.pop_front();
                        chk("done_rd_data", 64'(o_rd_data), 64'(c.rd));
                        chk("done_err", 64'(o_err), 64'(c.err));
                    end
                end
                prev_v = o_mem_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0; i_clk_ce = 1'b1; i_req_rd = 1'b1; i_req_wr = 4'b0000;
        i_addr = 32'h0000_0000; i_wr_data = 32'h0000_0000; i_mem_ready = 1'b0; i_mem_rdata = 32'h0;
        #2;
        chk("rst_ce", 64'(o_ce), 64'(1'b1));
        chk("rst_valid", 64'(o_mem_valid), 64'(1'b0));
        chk("rst_addr", 64'(o_mem_addr), 64'h0);
        chk("rst_we_be", 64'({o_mem_we, o_mem_be}), 64'h0);
        chk("rst_wdata_rd", {o_mem_wdata, o_rd_data}, 64'h0);
        chk("rst_err", 64'(o_err), 64'(1'b0));
        i_req_rd = 1'b0;
        @(negedge i_clk); #2;
        i_rst_n = 1'b1;

        // Minimum latency and a read with ready on the second wait cycle.
        run_txn(1'b1, 4'b0000, 32'h0000_0010, 32'h0, 1, 32'h1111_2222, 2);
        run_txn(1'b1, 4'b0000, 32'h0000_1004, 32'h0, 2, 32'hCAFE_F00D, 3);

`ifdef DMEM_WBUF_EN
        // First write absorbed, second write stalls one cycle behind the drain.
        @(posedge i_clk); #1;
        i_req_wr = 4'b0011; i_addr = 32'h0000_2002; i_wr_data = 32'h0000_BEEF;
        push_txn(1'b0, 4'b0011, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1);
        @(negedge i_clk);
        chk("wbuf_absorb_ce", 64'(o_ce), 64'(1'b1));
        @(posedge i_clk); #1;
        i_req_wr = 4'b1100; i_addr = 32'h0000_2004; i_wr_data = 32'hCAFE_0000;
        push_txn(1'b0, 4'b1100, 32'h0000_2004, 32'hCAFE_0000, 32'h0, 1);
        @(negedge i_clk);
        chk("wbuf_second_stall", 64'(o_ce), 64'(1'b0));
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        chk("wbuf_second_absorb", 64'(o_ce), 64'(1'b1));
        @(posedge i_clk); #1;
        i_req_wr = 4'b0000;
        @(negedge i_clk);
        chk("wbuf_drain_ce", 64'(o_ce), 64'(1'b1));
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
`else
        run_txn(1'b0, 4'b0011, 32'h0000_2002, 32'h0000_BEEF, 3, 32'h0, 4);
`endif

        // Read+write collision, then ready arriving on the timeout cycle.
        run_txn(1'b1, 4'b1111, 32'h0000_4000, 32'h5555_AAAA, 1, 32'h9999_9999, 2);
        run_txn(1'b1, 4'b0000, 32'h0000_4404, 32'h0, 4, 32'h7777_0001, 5);

        // Request while the upstream enable is low is ignored.
        @(posedge i_clk); #1;
        i_clk_ce = 1'b0; i_req_rd = 1'b1; i_addr = 32'h0000_3000;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("ce_low_no_issue", 64'({o_mem_valid, o_ce}), 64'h0);
        end
        @(posedge i_clk); #1;
        i_req_rd = 1'b0; i_clk_ce = 1'b1;
        @(negedge i_clk);
        chk("ce_low_idle", 64'({o_mem_valid, o_ce}), 64'h1);

        // DONE held by a low enable for three cycles.
        @(posedge i_clk); #1;
        i_req_rd = 1'b1; i_addr = 32'h0000_3008; i_wr_data = 32'h0; i_mem_rdata = 32'h1234_5678;
        push_txn(1'b1, 4'b0000, 32'h0000_3008, 32'h0, 32'h1234_5678, 1);
        @(negedge i_clk);
        chk("hold_idle_stall", 64'(o_ce), 64'(1'b0));
        @(negedge i_clk);
        chk("hold_wait_valid", 64'(o_mem_valid), 64'(1'b1));
        i_mem_ready = 1'b1; i_clk_ce = 1'b0;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("hold_done_data", 64'({o_ce, o_rd_data}), 64'({1'b0, 32'h1234_5678}));
            if (i < 2) @(negedge i_clk);
        end
        i_clk_ce = 1'b1;
        #1;
        chk("hold_done_release", 64'(o_ce), 64'(1'b1));
        @(posedge i_clk); #1;
        i_req_rd = 1'b0;
        @(negedge i_clk);
        chk("hold_after", 64'({o_mem_valid, o_ce, o_rd_data}), 64'({1'b0, 1'b1, 32'h1234_5678}));

        // Timeout, then sticky error on a normal read.
        run_txn(1'b1, 4'b0000, 32'h0000_5000, 32'h0, 0, 32'h1212_1212, 5);
        run_txn(1'b1, 4'b0000, 32'h0000_5004, 32'h0, 1, 32'h3456_789A, 2);

        // Reset in WAIT abandons the transaction asynchronously.
        @(posedge i_clk); #1;
        i_req_rd = 1'b1; i_addr = 32'h0000_6000;
        push_mem(4'b0000, 32'h0000_6000, 32'h0);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_wait_valid_pre", 64'(o_mem_valid), 64'(1'b1));
        @(posedge i_clk); #3;
        i_rst_n = 1'b0;
        #1;
        chk("rst_wait_valid", 64'(o_mem_valid), 64'(1'b0));
        chk("rst_wait_ce", 64'(o_ce), 64'(i_clk_ce));
        chk("rst_wait_regs", 64'({o_err, o_mem_addr, o_rd_data[30:0]}), 64'h0);
        i_req_rd = 1'b0;
        exp_err = 1'b0;
        exp_rd  = 32'h0000_0000;
        @(negedge i_clk); #2;
        i_rst_n = 1'b1;

        run_txn(1'b1, 4'b0000, 32'h0000_7000, 32'h0, 1, 32'hA5A5_5A5A, 2);

        repeat (2) @(negedge i_clk);
        chk("mem_queue_empty", 64'(mq.size()), 64'h0);
        chk("done_queue_empty", 64'(cq.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
